// File: rtl/dac_spi_pkg.sv
// Shared constants, state encoding and frame packing for the DAC SPI transmitter.
package dac_spi_pkg;

    localparam int DAC_FRAME_W    = 16;
    localparam int DAC_DATA_W     = 12;
    localparam int DAC_BIT_GA_N   = 13;
    localparam int DAC_BIT_SHDN_N = 12;
    localparam int DAC_CLK_DIV    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } dac_spi_state_t;

    // Channel A write; GA_n and SHDN_n are active-low on the DAC.
    function automatic logic [DAC_FRAME_W-1:0] dac_frame(
        input logic [DAC_DATA_W-1:0] code,
        input logic                  gain,
        input logic                  shutdown
    );
        logic [DAC_FRAME_W-1:0] w;
        w                 = '0;
        w[DAC_DATA_W-1:0] = code;
        w[DAC_BIT_GA_N]   = ~gain;
        w[DAC_BIT_SHDN_N] = ~shutdown;
        return w;
    endfunction

endpackage

// File: rtl/tick_counter.sv
// Modulo-CLK_DIV down-counter; tick is high in the last cycle of every period.
module tick_counter #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= LAST;
        end else if (clear || count == '0) begin
            count <= LAST;
        end else begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/dac_spi_tx.sv
// Handshake-driven 16-bit SPI mode 0 write-frame serializer for the 12-bit DAC.
//
// state | meaning
// IDLE  | ready for a sample, bus idle
// LOAD  | csn low, bit 15 set up before first rising sclk
// SHIFT | 32 sclk half-periods, data advances on falling edges
// HOLD  | sclk low, csn still low after last bit
// GAP   | csn high, minimum spacing before next frame
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int CLK_DIV = DAC_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DAC_DATA_W-1:0] data,
    input  logic                  gain,
    input  logic                  shutdown,
    input  logic                  valid,
    output logic                  ready,
    output logic                  dac_csn,
    output logic                  dac_sclk,
    output logic                  dac_sdi,
    output logic                  busy
);

    dac_spi_state_t         state, state_d;
    logic [DAC_FRAME_W-1:0] sreg, sreg_d, frame;
    logic [4:0]             half, half_d;
    logic                   csn_d, sclk_d, sdi_d;
    logic                   tick;

    assign frame = dac_frame(data, gain, shutdown);

    tick_counter #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            sreg     <= '0;
            half     <= '0;
            dac_csn  <= 1'b1;
            dac_sclk <= 1'b0;
            dac_sdi  <= 1'b0;
            ready    <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            sreg     <= sreg_d;
            half     <= half_d;
            dac_csn  <= csn_d;
            dac_sclk <= sclk_d;
            dac_sdi  <= sdi_d;
            ready    <= (state_d == ST_IDLE);
            busy     <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        half_d  = half;
        csn_d   = dac_csn;
        sclk_d  = dac_sclk;
        sdi_d   = dac_sdi;
        case (state)
            ST_IDLE: begin
                if (valid) begin
                    state_d = ST_LOAD;
                    sreg_d  = frame;
                    half_d  = '0;
                    csn_d   = 1'b0;
                    sclk_d  = 1'b0;
                    sdi_d   = frame[DAC_FRAME_W-1];
                end
            end
            ST_LOAD: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b1;
                    half_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (half == 5'd31) begin
                        state_d = ST_HOLD;
                        sclk_d  = 1'b0;
                    end else begin
                        half_d = half + 5'd1;
                        sclk_d = ~dac_sclk;
                        // Falling edge: move to next bit, except after bit 0.
                        if (dac_sclk && half != 5'd30) begin
                            sreg_d = {sreg[DAC_FRAME_W-2:0], 1'b0};
                            sdi_d  = sreg[DAC_FRAME_W-2];
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d = ST_GAP;
                    csn_d   = 1'b1;
                    sdi_d   = 1'b0;
                    half_d  = '0;
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (half == 5'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        half_d = half + 5'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                csn_d   = 1'b1;
                sclk_d  = 1'b0;
                sdi_d   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: instance 0 at CLK_DIV=5, instance 1 at CLK_DIV=1, frames decoded on sclk rising edges.
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] data_i[2];
    logic        gain_i[2], shdn_i[2], valid_i[2];
    logic        ready_o[2], csn_o[2], sclk_o[2], sdi_o[2], busy_o[2];

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    // Frame monitor state, per instance.
    logic [15:0] cur_word[2];
    int          cur_rise[2], cur_low[2];
    logic        pcsn[2], psclk[2];
    logic [15:0] hist_word[2][16];
    int          hist_rise[2][16], hist_low[2][16];
    int          nfr[2];

    typedef struct {
        logic [11:0] data;
        logic        gain;
        logic        shutdown;
        logic [15:0] word;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_tx #(.CLK_DIV(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .data(data_i[0]), .gain(gain_i[0]),
        .shutdown(shdn_i[0]), .valid(valid_i[0]), .ready(ready_o[0]),
        .dac_csn(csn_o[0]), .dac_sclk(sclk_o[0]), .dac_sdi(sdi_o[0]), .busy(busy_o[0])
    );

    dac_spi_tx #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .data(data_i[1]), .gain(gain_i[1]),
        .shutdown(shdn_i[1]), .valid(valid_i[1]), .ready(ready_o[1]),
        .dac_csn(csn_o[1]), .dac_sclk(sclk_o[1]), .dac_sdi(sdi_o[1]), .busy(busy_o[1])
    );

    initial begin
        for (int i = 0; i < 2; i++) begin
            cur_word[i] = '0; cur_rise[i] = 0; cur_low[i] = 0;
            pcsn[i] = 1'b1; psclk[i] = 1'b0; nfr[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (csn_o[i] === 1'b0) begin
                cur_low[i] = cur_low[i] + 1;
                if (sclk_o[i] === 1'b1 && psclk[i] === 1'b0) begin
                    cur_word[i] = {cur_word[i][14:0], sdi_o[i]};
                    cur_rise[i] = cur_rise[i] + 1;
                end
            end else if (pcsn[i] === 1'b0) begin
                hist_word[i][nfr[i] % 16] = cur_word[i];
                hist_rise[i][nfr[i] % 16] = cur_rise[i];
                hist_low[i][nfr[i] % 16]  = cur_low[i];
                nfr[i] = nfr[i] + 1;
                cur_word[i] = '0; cur_rise[i] = 0; cur_low[i] = 0;
            end
            pcsn[i]  = csn_o[i];
            psclk[i] = sclk_o[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int i);
        int n = 0;
        @(negedge clk);
        while (ready_o[i] !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (ready_o[i] !== 1'b1) chk("ready_timeout", 32'(ready_o[i]), 1);
    endtask

    task automatic wait_frames(input int i, input int target);
        int n = 0;
        while (nfr[i] < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (nfr[i] < target) chk("frame_timeout", nfr[i], target);
    endtask

    task automatic send(input int i, input logic [11:0] d, input logic g, input logic s);
        wait_ready(i);
        data_i[i] = d; gain_i[i] = g; shdn_i[i] = s; valid_i[i] = 1'b1;
        @(posedge clk);
        #1 valid_i[i] = 1'b0;
    endtask

    task automatic check_frame(input int i, input int idx, input logic [15:0] w, input int low);
        chk("word", 32'(hist_word[i][idx % 16]), 32'(w));
        chk("rises", hist_rise[i][idx % 16], 16);
        chk("csn_low", hist_low[i][idx % 16], low);
    endtask

    initial begin
        int base;
        int hs[3];
        vecs[0] = '{12'hABC, 1'b1, 1'b0, 16'h1ABC};
        vecs[1] = '{12'hABC, 1'b0, 1'b0, 16'h3ABC};
        vecs[2] = '{12'hABC, 1'b1, 1'b1, 16'h0ABC};
        vecs[3] = '{12'hFFF, 1'b0, 1'b0, 16'h3FFF};
        vecs[4] = '{12'h000, 1'b1, 1'b1, 16'h0000};
        vecs[5] = '{12'h5A3, 1'b0, 1'b1, 16'h25A3};
        for (int i = 0; i < 2; i++) begin
            data_i[i] = '0; gain_i[i] = 1'b0; shdn_i[i] = 1'b0; valid_i[i] = 1'b0;
        end

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_csn", 32'(csn_o[i]), 1);
            chk("rst_sclk", 32'(sclk_o[i]), 0);
            chk("rst_sdi", 32'(sdi_o[i]), 0);
            chk("rst_ready", 32'(ready_o[i]), 1);
            chk("rst_busy", 32'(busy_o[i]), 0);
        end
        rst_n = 1'b1;

        // Table-driven single frames at CLK_DIV=5.
        for (int v = 0; v < 6; v++) begin
            base = nfr[0];
            send(0, vecs[v].data, vecs[v].gain, vecs[v].shutdown);
            chk("busy_in_frame", 32'(busy_o[0]), 1);
            wait_frames(0, base + 1);
            check_frame(0, base, vecs[v].word, 170);
        end

        // Back-to-back with valid held high, data 0,1,2.
        base = nfr[0];
        wait_ready(0);
        data_i[0] = 12'h000; gain_i[0] = 1'b1; shdn_i[0] = 1'b0; valid_i[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_ready(0);
            @(posedge clk);
            #1;
            hs[k] = cyc;
            chk("b2b_ready_drop", 32'(ready_o[0]), 0);
            data_i[0] = 12'(k + 1);
        end
        valid_i[0] = 1'b0;
        wait_frames(0, base + 3);
        for (int k = 0; k < 3; k++) check_frame(0, base + k, 16'h1000 + 16'(k), 170);
        chk("b2b_period_1", hs[1] - hs[0], 181);
        chk("b2b_period_2", hs[2] - hs[1], 181);

        // valid pulse while busy is ignored.
        base = nfr[0];
        send(0, 12'hABC, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        data_i[0] = 12'h555; valid_i[0] = 1'b1;
        @(posedge clk);
        #1 valid_i[0] = 1'b0;
        wait_frames(0, base + 1);
        check_frame(0, base, 16'h1ABC, 170);
        repeat (250) @(negedge clk);
        chk("no_extra_frame", nfr[0], base + 1);
        chk("idle_after_ignore", 32'(busy_o[0]), 0);

        // Reset 60 cycles into a frame.
        base = nfr[0];
        send(0, 12'h123, 1'b1, 1'b0);
        repeat (59) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_csn", 32'(csn_o[0]), 1);
        chk("abort_sclk", 32'(sclk_o[0]), 0);
        chk("abort_sdi", 32'(sdi_o[0]), 0);
        chk("abort_ready", 32'(ready_o[0]), 1);
        chk("abort_busy", 32'(busy_o[0]), 0);
        rst_n = 1'b1;
        wait_frames(0, base + 1);
        chk("abort_truncated", 32'(hist_rise[0][base % 16] < 16), 1);
        send(0, 12'h456, 1'b0, 1'b1);
        wait_frames(0, base + 2);
        check_frame(0, base + 1, 16'h2456, 170);

        // CLK_DIV=1 instance.
        for (int v = 0; v < 4; v += 3) begin
            base = nfr[1];
            send(1, vecs[v].data, vecs[v].gain, vecs[v].shutdown);
            wait_frames(1, base + 1);
            check_frame(1, base, vecs[v].word, 34);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
